inst_fetch_unit: RTL and testbench

//  Fetch stage upstream of the decoder/ControlUnit.
//  - Reads a byte-wide synchronous instruction ROM one byte per cycle.
//  - Assembles each 32-bit big-endian instruction word: byte at pc -> bits[31:24].
//  - Presents the word with its pc and pc+4 over a valid/ready handshake.
//  - Accepts branch/jump redirects from the PC-select logic; flags misaligned or out-of-range fetches.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/inst_word_assembler.sv | 42 ++++
 rtl/inst_fetch_unit.sv | 139 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions.
//   - fetch_state_e : fetch FSM encoding (2 bits)
//   - BYTES_PER_INST: bytes per instruction word
//   - OP_*          : primary opcodes decoded by ControlUnit
//   - pc_fault()    : misaligned / out-of-range fetch address test
package mips_pkg;

  localparam int BYTES_PER_INST = 4;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_DRAIN = 2'd1,
    FS_VALID = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // The last legal word starts at imem_bytes-4. Any pc that wrapped past
  // the top of the 32-bit space lands far above that, so it is caught too.
  function automatic logic pc_fault(input logic [31:0] pc,
                                    input logic [31:0] imem_bytes);
    return (pc[1:0] != 2'b00) || (pc > imem_bytes - 32'(BYTES_PER_INST));
  endfunction

endpackage

// File: rtl/inst_word_assembler.sv
// 8->32 big-endian shift register: the first captured byte ends up in [31:23+1].
// Ports:
//   clock, reset  : clock, async active-high reset
//   clear         : drop all partial bytes (wins over capture)
//   capture       : shift rd_byte in this cycle
//   rd_byte       : ROM byte
//   word_next     : word including the byte being captured this cycle
//   done          : 4th byte of a word is being captured this cycle
module inst_word_assembler
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        capture,
  input  logic [7:0]  rd_byte,
  output logic [31:0] word_next,
  output logic        done
);

  logic [31:0] word;
  logic [1:0]  byte_cnt;

  assign word_next = {word[23:0], rd_byte};
  assign done      = capture && !clear && (byte_cnt == 2'(BYTES_PER_INST - 1));

  // byte_cnt wraps to 0 on the 4th capture, so the next word starts clean
  // without an explicit clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (capture) begin
      word     <= word_next;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: reads a byte-wide synchronous ROM four bytes per
// word, assembles big-endian words and hands them to the decoder over a
// valid/ready handshake. Takes redirects and flags bad fetch addresses.
// Ports:
//   clock, reset                       : clock, async active-high reset
//   redirect_valid, redirect_pc        : branch/jump redirect (highest priority)
//   mem_rd_en, mem_addr, mem_rd_data   : ROM read port (data 1 cycle after en)
//   inst_valid, inst_ready             : decoder handshake
//   inst_word, inst_pc, inst_pc_plus4  : delivered word and its addresses
//   fetch_fault                        : sticky misaligned/out-of-range flag
module inst_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rd_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  output logic        fetch_fault
);

  localparam logic [31:0] IMEM_SIZE = 32'(IMEM_BYTES);
  localparam logic [31:0] PC_STEP   = 32'(BYTES_PER_INST);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_INST - 1);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [1:0]   cnt;
  logic         rd_pending;

  logic         entry;
  logic [31:0]  entry_pc;
  logic         entry_bad;
  logic [31:0]  asm_word_next;
  logic         asm_done;

  // Every way into FETCH: redirect (any state), accept, or the first cycle
  // after reset (state FETCH with no read issued yet). The address check and
  // the first read strobe are both set up on that edge, so mem_rd_en is a
  // plain register and reads 0 during reset.
  always_comb begin
    entry    = 1'b0;
    entry_pc = pc;
    if (redirect_valid) begin
      entry    = 1'b1;
      entry_pc = redirect_pc;
    end else if (state == FS_VALID && inst_ready) begin
      entry    = 1'b1;
      entry_pc = pc + PC_STEP;
    end else if (state == FS_FETCH && !mem_rd_en) begin
      entry    = 1'b1;
      entry_pc = pc;
    end
  end

  assign entry_bad = pc_fault(entry_pc, IMEM_SIZE);

  // A redirect drops whatever byte is still on its way back from the ROM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_pending <= 1'b0;
    else       rd_pending <= redirect_valid ? 1'b0 : mem_rd_en;
  end

  inst_word_assembler u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect_valid),
    .capture   (rd_pending),
    .rd_byte   (mem_rd_data),
    .word_next (asm_word_next),
    .done      (asm_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= FS_FETCH;
      pc            <= RESET_PC;
      cnt           <= '0;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      inst_valid    <= 1'b0;
      inst_word     <= '0;
      inst_pc       <= '0;
      inst_pc_plus4 <= '0;
      fetch_fault   <= 1'b0;
    end else if (entry) begin
      pc         <= entry_pc;
      cnt        <= '0;
      inst_valid <= 1'b0;
      if (entry_bad) begin
        state       <= FS_FAULT;
        fetch_fault <= 1'b1;
        mem_rd_en   <= 1'b0;
      end else begin
        state       <= FS_FETCH;
        fetch_fault <= 1'b0;
        mem_rd_en   <= 1'b1;
        mem_addr    <= entry_pc;
      end
    end else begin
      case (state)
        // cnt is the byte whose read is on the bus this cycle.
        FS_FETCH: begin
          if (cnt == LAST_BYTE) begin
            mem_rd_en <= 1'b0;
            state     <= FS_DRAIN;
          end else begin
            cnt      <= cnt + 2'd1;
            mem_addr <= pc + 32'(cnt) + 32'd1;
          end
        end
        // Last byte arrives this cycle; publish the word with it folded in.
        FS_DRAIN: begin
          if (asm_done) begin
            state         <= FS_VALID;
            inst_valid    <= 1'b1;
            inst_word     <= asm_word_next;
            inst_pc       <= pc;
            inst_pc_plus4 <= pc + PC_STEP;
          end
        end
        // VALID waits for accept (handled as an entry); FAULT parks until a
        // good redirect.
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          IMEM_BYTES = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        inst_valid;
  logic [31:0] inst_word, inst_pc, inst_pc_plus4;
  logic        fetch_fault;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_word(inst_word), .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  // Synchronous byte ROM: data is valid the cycle after the read strobe.
  logic [7:0] rom [IMEM_BYTES];
  always @(posedge clock)
    if (mem_rd_en)
      mem_rd_data <= (mem_addr < 32'(IMEM_BYTES)) ? rom[mem_addr[5:0]] : 8'h00;

  int total = 0;
  int bad   = 0;

  // Reference model, transaction level: the address of the word being
  // fetched, and edges elapsed since the fetch of it began. Reads occupy
  // the first four cycles after entry and the word is up five edges after it.
  logic [31:0] m_pc;
  int          m_since;
  logic        m_valid;

  typedef struct {
    logic [31:0] target;
    logic        fault;
    logic [31:0] word;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic pc_ok(input logic [31:0] p);
    return (p % 4 == 0) && (p + 4 <= 32'(IMEM_BYTES));
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {rom[a[5:0]], rom[a[5:0] + 6'd1], rom[a[5:0] + 6'd2], rom[a[5:0] + 6'd3]};
  endfunction

  task automatic check_all();
    logic ok, rd;
    ok      = pc_ok(m_pc) && (m_pc + 4 > m_pc);
    m_valid = ok && m_since >= 5;
    rd      = ok && m_since >= 0 && m_since <= 3;
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("fetch_fault", 32'(fetch_fault), 32'(!ok));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(rd));
    if (rd) chk("mem_addr", mem_addr, m_pc + 32'(m_since));
    if (m_valid) begin
      chk("inst_pc", inst_pc, m_pc);
      chk("inst_pc_plus4", inst_pc_plus4, m_pc + 32'd4);
      chk("inst_word", inst_word, rom_word(m_pc));
    end
  endtask

  // One clock: apply the inputs held over the edge to the model, then check.
  task automatic cyc();
    logic acc, rdr;
    logic [31:0] rpc;
    acc = m_valid && inst_ready;
    rdr = redirect_valid;
    rpc = redirect_pc;
    @(posedge clock); #1;
    if (rdr) begin m_pc = rpc; m_since = 0; end
    else if (acc) begin m_pc = m_pc + 32'd4; m_since = 0; end
    else if (m_since < 100) m_since++;
    check_all();
  endtask

  // Called #1 after an edge: reset lands mid-cycle and must clear outputs
  // with no clock edge. The cycle after release is the entry check, so the
  // model starts one edge behind a normal entry.
  task automatic do_reset();
    #3 reset = 1'b1;
    #1;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_word", inst_word, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_pc4", inst_pc_plus4, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    @(posedge clock); #1;
    reset   = 1'b0;
    m_pc    = RESET_PC;
    m_since = -1;
    m_valid = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] p);
    redirect_valid = 1'b1;
    redirect_pc    = p;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < IMEM_BYTES; i++) rom[i] = 8'(i) ^ 8'hA5;
    rom[0] = 8'h20; rom[1] = 8'h01; rom[2] = 8'h00; rom[3] = 8'h05;

    tbl[0] = '{32'd0,        1'b0, 32'h2001_0005};
    tbl[1] = '{32'd4,        1'b0, 32'hA1A0_A3A2};
    tbl[2] = '{32'd28,       1'b0, 32'hB9B8_BBBA};
    tbl[3] = '{32'd60,       1'b0, 32'h9998_9B9A};
    tbl[4] = '{32'd6,        1'b1, 32'h0};
    tbl[5] = '{32'd64,       1'b1, 32'h0};
    tbl[6] = '{32'hFFFF_FFFC, 1'b1, 32'h0};
    tbl[7] = '{32'd61,       1'b1, 32'h0};
    tbl[8] = '{32'd8,        1'b0, 32'hADAC_AFAE};

    m_pc = RESET_PC; m_since = -1; m_valid = 1'b0;
    do_reset();

    // First word after reset, then a 10-cycle stall.
    repeat (6) cyc();
    chk("t1_valid", 32'(inst_valid), 32'd1);
    chk("t1_word", inst_word, 32'h2001_0005);
    chk("t1_pc", inst_pc, 32'd0);
    chk("t1_pc4", inst_pc_plus4, 32'd4);
    repeat (10) begin
      cyc();
      chk("t2_hold_word", inst_word, 32'h2001_0005);
      chk("t2_hold_rd_en", 32'(mem_rd_en), 32'd0);
    end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    repeat (5) cyc();
    chk("t2_next_pc", inst_pc, 32'd4);
    chk("t2_next_word", inst_word, 32'hA1A0_A3A2);

    // Redirect while byte 2 of the word at 8 is being read.
    redirect(32'd8);
    cyc(); cyc();
    chk("t3_mid_addr", mem_addr, 32'd10);
    redirect(32'd28);
    repeat (5) cyc();
    chk("t3_pc", inst_pc, 32'd28);
    chk("t3_word", inst_word, 32'hB9B8_BBBA);

    // Misaligned redirect faults, stays sticky, good redirect recovers.
    redirect(32'd6);
    chk("t4_fault", 32'(fetch_fault), 32'd1);
    chk("t4_rd_en", 32'(mem_rd_en), 32'd0);
    repeat (3) cyc();
    chk("t4_sticky", 32'(fetch_fault), 32'd1);
    redirect(32'd0);
    chk("t4_cleared", 32'(fetch_fault), 32'd0);
    chk("t4_resume", 32'(mem_rd_en), 32'd1);
    repeat (5) cyc();
    chk("t4_word", inst_word, 32'h2001_0005);

    // Run off the end of the ROM.
    redirect(32'd56);
    repeat (5) cyc();
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    repeat (5) cyc();
    chk("t5_pc", inst_pc, 32'd60);
    chk("t5_word", inst_word, 32'h9998_9B9A);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk("t5_fault", 32'(fetch_fault), 32'd1);
    chk("t5_valid", 32'(inst_valid), 32'd0);

    // Redirect target table.
    for (int i = 0; i < 9; i++) begin
      redirect(tbl[i].target);
      repeat (5) cyc();
      chk("tbl_fault", 32'(fetch_fault), 32'(tbl[i].fault));
      chk("tbl_valid", 32'(inst_valid), 32'(!tbl[i].fault));
      if (!tbl[i].fault) begin
        chk("tbl_pc", inst_pc, tbl[i].target);
        chk("tbl_word", inst_word, tbl[i].word);
      end
    end

    // Reset while VALID, then mid-FETCH.
    do_reset();
    cyc(); cyc();
    do_reset();
    repeat (6) cyc();
    chk("t6_valid", 32'(inst_valid), 32'd1);
    chk("t6_pc", inst_pc, RESET_PC);

    // Random ready / redirect traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      inst_ready     = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 9))
        0:       redirect_pc = 32'($urandom_range(0, 63)) | 32'h1;
        1:       redirect_pc = 32'($urandom_range(16, 40)) * 32'd4;
        default: redirect_pc = 32'($urandom_range(0, 15)) * 32'd4;
      endcase
      cyc();
    end
    redirect_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
